ysyx_23060191_mem_arb: RTL

Two-requester memory arbiter and sequencer between the instruction fetch unit (IFU) and the load/store unit (LSU). Both units share a single memory port. The block accepts one request at a time, latches it, and drives the memory request handshake. It routes the response back to the owning unit and recovers from a missing response with a timeout error. It sits between the IFU/LSU and the memory model, replacing their direct memory instances.

---
 rtl/ysyx_23060191_mem_arb_pkg.sv | 18 +
 rtl/ysyx_23060191_mem_arb_if.sv | 24 ++
 rtl/ysyx_23060191_rr_pick.sv | 23 ++
 rtl/ysyx_23060191_mem_arb.sv | 135 +++++++++++++
 4 files changed

// File: rtl/ysyx_23060191_mem_arb_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states, owner ids and
// the default CPU datapath width.
package ysyx_23060191_mem_arb_pkg;

  localparam int CPU_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/ysyx_23060191_mem_arb_if.sv
// Shared memory port between the arbiter (master) and the memory model (slave).
interface ysyx_23060191_mem_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [AW-1:0]   mem_addr;
  logic            mem_wen;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wmask;
  logic            mem_resp_valid;
  logic [DW-1:0]   mem_rdata;

  modport master (
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/ysyx_23060191_rr_pick.sv
// Two-way round-robin picker: on a tie the unit not granted last time wins.
module ysyx_23060191_rr_pick (
  input  logic       ifu_valid,
  input  logic       lsu_valid,
  input  logic       last_owner,
  output logic [1:0] grant,
  output logic       winner
);

  always_comb begin
    winner = 1'b0;
    grant  = 2'b00;
    if (ifu_valid && lsu_valid) begin
      winner = ~last_owner;
    end else if (lsu_valid) begin
      winner = 1'b1;
    end
    if (ifu_valid || lsu_valid) begin
      grant = winner ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ysyx_23060191_mem_arb.sv
// IFU/LSU memory arbiter: accepts one request at a time, drives the shared
// memory port, routes the response to its owner and times out lost responses.
module ysyx_23060191_mem_arb
  import ysyx_23060191_mem_arb_pkg::*;
#(
  parameter int AW      = CPU_WIDTH,
  parameter int DW      = CPU_WIDTH,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_addr,
  output logic            ifu_resp_valid,
  output logic [DW-1:0]   ifu_rdata,
  output logic            ifu_resp_err,

  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_addr,
  input  logic            lsu_wen,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wmask,
  output logic            lsu_resp_valid,
  output logic [DW-1:0]   lsu_rdata,
  output logic            lsu_resp_err,

  ysyx_23060191_mem_arb_if.master mem
);

  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  owner_e          owner_q, last_owner_q;
  logic [TW-1:0]   cnt_q;
  logic [AW-1:0]   addr_q;
  logic            wen_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] wmask_q;

  logic [1:0]      grant;
  logic            winner;
  logic            accept;
  logic            resp_fire;
  logic            resp_err;
  logic            idle_ok;

  ysyx_23060191_rr_pick u_pick (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
    .last_owner (last_owner_q),
    .grant      (grant),
    .winner     (winner)
  );

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    resp_fire = 1'b0;
    resp_err  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          accept  = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem.mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A real response takes priority over a timeout landing on the same cycle.
        if (mem.mem_resp_valid) begin
          resp_fire = 1'b1;
          state_d   = ST_IDLE;
        end else if (cnt_q == TO_LAST) begin
          resp_fire = 1'b1;
          resp_err  = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IFU;
      last_owner_q <= OWN_IFU;
      cnt_q        <= '0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q      <= owner_e'(winner);
        last_owner_q <= owner_e'(winner);
        // Fetches are always full-word reads regardless of the LSU-side inputs.
        addr_q       <= winner ? lsu_addr  : ifu_addr;
        wen_q        <= winner & lsu_wen;
        wdata_q      <= winner ? lsu_wdata : '0;
        wmask_q      <= winner ? lsu_wmask : '1;
      end
      if (state_q == ST_REQ && mem.mem_req_ready) begin
        cnt_q <= '0;
      end else if (state_q == ST_WAIT && !mem.mem_resp_valid) begin
        cnt_q <= cnt_q + TW'(1);
      end
    end
  end

  assign idle_ok       = (state_q == ST_IDLE) && !rst;
  assign ifu_req_ready = idle_ok && grant[0];
  assign lsu_req_ready = idle_ok && grant[1];

  assign mem.mem_req_valid = (state_q == ST_REQ);
  assign mem.mem_addr      = addr_q;
  assign mem.mem_wen       = wen_q;
  assign mem.mem_wdata     = wdata_q;
  assign mem.mem_wmask     = wmask_q;

  assign ifu_resp_valid = resp_fire && (owner_q == OWN_IFU);
  assign lsu_resp_valid = resp_fire && (owner_q == OWN_LSU);
  assign ifu_resp_err   = ifu_resp_valid && resp_err;
  assign lsu_resp_err   = lsu_resp_valid && resp_err;
  assign ifu_rdata      = (ifu_resp_valid && !resp_err) ? mem.mem_rdata : '0;
  assign lsu_rdata      = (lsu_resp_valid && !resp_err) ? mem.mem_rdata : '0;

endmodule
